// File: rtl/huffman_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | huffman_pkg                                                                |
// | Shared Huffman constants, FSM encoding and popcount helper.                |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package huffman_pkg;

    localparam int SYM_NUM = 6;
    localparam int CODE_W  = 8;
    localparam int ACC_W   = 16;
    localparam int LEN_W   = 4;
    localparam int SYM_MIN = 1;
    localparam int SYM_MAX = 6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    function automatic logic [LEN_W-1:0] popcount(input logic [CODE_W-1:0] v);
        logic [LEN_W-1:0] n;
        n = '0;
        for (int i = 0; i < CODE_W; i++) begin
            n = n + LEN_W'(v[i]);
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/huffman_code_rom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | huffman_code_rom                                                           |
// | Code table register file with popcount length decode, read by index.      |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module huffman_code_rom
    import huffman_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      load,
    input  logic [SYM_NUM*CODE_W-1:0] hc_flat,
    input  logic [SYM_NUM*CODE_W-1:0] m_flat,
    input  logic [2:0]                rd_idx,
    output logic [CODE_W-1:0]         rd_code,
    output logic [LEN_W-1:0]          rd_len
);

    logic [CODE_W-1:0] r_code [SYM_NUM];
    logic [LEN_W-1:0]  r_len  [SYM_NUM];

    // Codes are stored pre-masked so the packer can OR them in directly.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYM_NUM; i++) begin
                r_code[i] <= '0;
                r_len[i]  <= '0;
            end
        end else if (load) begin
            for (int i = 0; i < SYM_NUM; i++) begin
                r_code[i] <= hc_flat[i*CODE_W +: CODE_W] & m_flat[i*CODE_W +: CODE_W];
                r_len[i]  <= popcount(m_flat[i*CODE_W +: CODE_W]);
            end
        end
    end

    always_comb begin
        rd_code = '0;
        rd_len  = '0;
        if (rd_idx < 3'(SYM_NUM)) begin
            rd_code = r_code[rd_idx];
            rd_len  = r_len[rd_idx];
        end
    end

endmodule

`default_nettype wire

// File: rtl/huffman_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | huffman_packer                                                             |
// | Encodes symbols 1..6 into MSB-first codewords packed into bytes.           |
// | Optional: PACKER_STATS_EN adds the total_bits counter port.                |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module huffman_packer
    import huffman_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] HC1,
    input  logic [CODE_W-1:0] HC2,
    input  logic [CODE_W-1:0] HC3,
    input  logic [CODE_W-1:0] HC4,
    input  logic [CODE_W-1:0] HC5,
    input  logic [CODE_W-1:0] HC6,
    input  logic [CODE_W-1:0] M1,
    input  logic [CODE_W-1:0] M2,
    input  logic [CODE_W-1:0] M3,
    input  logic [CODE_W-1:0] M4,
    input  logic [CODE_W-1:0] M5,
    input  logic [CODE_W-1:0] M6,
    input  logic              sym_valid,
    input  logic [7:0]        sym_data,
    output logic              sym_ready,
    input  logic              flush,
    output logic              byte_valid,
    output logic [7:0]        byte_data,
    output logic              byte_last,
    input  logic              byte_ready,
    output logic              sym_err
`ifdef PACKER_STATS_EN
    ,
    output logic [15:0]       total_bits
`endif
);

    localparam int CNT_W = LEN_W + 1;
    localparam logic [CNT_W-1:0] c_BYTE_BITS = CNT_W'(8);

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic               r_flush_pending;
    logic               r_byte_valid;
    logic [7:0]         r_byte_data;
    logic               r_byte_last;
    logic               r_sym_err;

    logic               w_load;
    logic               w_sym_ready;
    logic               w_accept;
    logic               w_legal;
    logic               w_append;
    logic [2:0]         w_idx;
    logic [CODE_W-1:0]  w_rom_code;
    logic [LEN_W-1:0]   w_rom_len;
    logic [ACC_W-1:0]   w_acc_app;
    logic [CNT_W-1:0]   w_cnt_app;
    logic               w_slot_free;
    logic               w_emit;
    logic               w_pad;
    logic               w_flushing;
    logic               w_mark_held;
    logic [7:0]         w_emit_byte;
    logic [7:0]         w_pad_byte;

    huffman_code_rom u_rom (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (w_load),
        .hc_flat ({HC6, HC5, HC4, HC3, HC2, HC1}),
        .m_flat  ({M6, M5, M4, M3, M2, M1}),
        .rd_idx  (w_idx),
        .rd_code (w_rom_code),
        .rd_len  (w_rom_len)
    );

    assign w_load      = (r_state == ST_IDLE) && code_valid;
    assign w_sym_ready = (r_state == ST_RUN) && (r_bit_cnt < c_BYTE_BITS) && !r_flush_pending;
    assign w_accept    = sym_valid && w_sym_ready;
    assign w_legal     = (sym_data >= 8'(SYM_MIN)) && (sym_data <= 8'(SYM_MAX));
    assign w_append    = w_accept && w_legal;
    assign w_idx       = sym_data[2:0] - 3'd1;

    // Appended view of the accumulator; a byte can be cut from it in the accept cycle.
    assign w_acc_app   = w_append ? ((r_acc << w_rom_len) | ACC_W'(w_rom_code)) : r_acc;
    assign w_cnt_app   = r_bit_cnt + (w_append ? {1'b0, w_rom_len} : '0);
    assign w_slot_free = !r_byte_valid || byte_ready;
    assign w_flushing  = (r_state == ST_FLUSH) || ((r_state == ST_RUN) && flush);
    assign w_emit      = (r_state != ST_IDLE) && (w_cnt_app >= c_BYTE_BITS) && w_slot_free;
    assign w_pad       = (r_state == ST_FLUSH) && (r_bit_cnt != '0) &&
                         (r_bit_cnt < c_BYTE_BITS) && w_slot_free;
    assign w_mark_held = (r_state == ST_FLUSH) && (r_bit_cnt == '0) && r_byte_valid && !byte_ready;
    assign w_emit_byte = 8'(w_acc_app >> (w_cnt_app - c_BYTE_BITS));
    assign w_pad_byte  = 8'(r_acc << (c_BYTE_BITS - r_bit_cnt));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_acc           <= '0;
            r_bit_cnt       <= '0;
            r_flush_pending <= 1'b0;
            r_byte_valid    <= 1'b0;
            r_byte_data     <= '0;
            r_byte_last     <= 1'b0;
            r_sym_err       <= 1'b0;
        end else begin
            r_acc <= w_acc_app;
            if (w_emit) begin
                r_byte_valid <= 1'b1;
                r_byte_data  <= w_emit_byte;
                r_byte_last  <= w_flushing && (w_cnt_app == c_BYTE_BITS);
                r_bit_cnt    <= w_cnt_app - c_BYTE_BITS;
            end else if (w_pad) begin
                r_byte_valid <= 1'b1;
                r_byte_data  <= w_pad_byte;
                r_byte_last  <= 1'b1;
                r_bit_cnt    <= '0;
            end else begin
                r_bit_cnt <= w_cnt_app;
                if (byte_ready) begin
                    r_byte_valid <= 1'b0;
                end
                if (w_mark_held) begin
                    r_byte_last <= 1'b1;
                end
            end

            if (w_accept && !w_legal) begin
                r_sym_err <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_flush_pending <= 1'b0;
                    if (code_valid) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (flush) begin
                        r_flush_pending <= 1'b1;
                    end
                    if (flush || r_flush_pending) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    if ((r_bit_cnt == '0) && !r_byte_valid) begin
                        r_state         <= ST_IDLE;
                        r_flush_pending <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef PACKER_STATS_EN
    logic [15:0] r_total_bits;
    logic [16:0] w_total_sum;

    assign w_total_sum = {1'b0, r_total_bits} + {13'd0, w_rom_len};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_total_bits <= '0;
        end else if (w_load) begin
            r_total_bits <= '0;
        end else if (w_append) begin
            r_total_bits <= w_total_sum[16] ? 16'hFFFF : w_total_sum[15:0];
        end
    end

    assign total_bits = r_total_bits;
`endif

    assign sym_ready  = w_sym_ready;
    assign byte_valid = r_byte_valid;
    assign byte_data  = r_byte_data;
    assign byte_last  = r_byte_last;
    assign sym_err    = r_sym_err;

endmodule

`default_nettype wire

// File: tb/tb_huffman_packer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_huffman_packer                                                          |
// | Randomized scoreboard bench with a bit-queue reference model.              |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_huffman_packer;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        code_valid;
    logic [7:0]  hc [6];
    logic [7:0]  m  [6];
    logic        sym_valid;
    logic [7:0]  sym_data;
    logic        sym_ready;
    logic        flush;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_last;
    logic        byte_ready;
    logic        sym_err;
`ifdef PACKER_STATS_EN
    logic [15:0] total_bits;
`endif

    int          n_checks;
    int          n_fail;
    bit          br_mode;
    logic        br_val;
    logic [7:0]  tb_code [6];
    int          tb_len  [6];
    logic        mq [$];
    exp_t        exq [$];

    huffman_packer dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .code_valid (code_valid),
        .HC1        (hc[0]),
        .HC2        (hc[1]),
        .HC3        (hc[2]),
        .HC4        (hc[3]),
        .HC5        (hc[4]),
        .HC6        (hc[5]),
        .M1         (m[0]),
        .M2         (m[1]),
        .M3         (m[2]),
        .M4         (m[3]),
        .M5         (m[4]),
        .M6         (m[5]),
        .sym_valid  (sym_valid),
        .sym_data   (sym_data),
        .sym_ready  (sym_ready),
        .flush      (flush),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .sym_err    (sym_err)
`ifdef PACKER_STATS_EN
        ,
        .total_bits (total_bits)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        byte_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            byte_ready = br_mode ? 1'($urandom_range(0, 1)) : br_val;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    // Reference model: codewords become a plain bit stream, cut into bytes MSB first.
    task automatic model_sym(input logic [7:0] s);
        int         idx;
        logic [7:0] v;
        v = '0;
        if (s >= 8'd1 && s <= 8'd6) begin
            idx = int'(s) - 1;
            for (int b = tb_len[idx] - 1; b >= 0; b--) begin
                mq.push_back(tb_code[idx][b]);
            end
            while (mq.size() >= 8) begin
                for (int j = 0; j < 8; j++) begin
                    v = {v[6:0], mq.pop_front()};
                end
                exq.push_back('{d: v, l: 1'b0});
            end
        end
    endtask

    task automatic model_flush();
        logic [7:0] v;
        exp_t       e;
        v = '0;
        if (mq.size() > 0) begin
            for (int j = 0; j < 8; j++) begin
                v = {v[6:0], (j < mq.size()) ? mq[j] : 1'b0};
            end
            exq.push_back('{d: v, l: 1'b1});
            mq.delete();
        end else if (exq.size() > 0) begin
            e = exq.pop_back();
            e.l = 1'b1;
            exq.push_back(e);
        end
    endtask

    task automatic load_table();
        for (int i = 0; i < 6; i++) begin
            tb_code[i] = hc[i] & m[i];
            tb_len[i]  = $countones(m[i]);
        end
        code_valid = 1'b1;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
    endtask

    task automatic set_std_table();
        hc[0] = 8'h00; m[0] = 8'h01;
        hc[1] = 8'h02; m[1] = 8'h03;
        hc[2] = 8'h06; m[2] = 8'h07;
        hc[3] = 8'h0E; m[3] = 8'h0F;
        hc[4] = 8'h1E; m[4] = 8'h1F;
        hc[5] = 8'h1F; m[5] = 8'h1F;
    endtask

    task automatic send_sym(input logic [7:0] s, input bit with_flush);
        bit got;
        got       = 1'b0;
        sym_valid = 1'b1;
        sym_data  = s;
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (sym_ready) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL sym_accept_timeout: sym_ready actual 0 required 1");
            sym_valid = 1'b0;
            return;
        end
        flush = with_flush;
        @(posedge clk);
        model_sym(s);
        if (with_flush) model_flush();
        #1;
        sym_valid = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk);
        model_flush();
        #1;
        flush = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (exq.size() == 0) break;
        end
        chk(name, 32'(exq.size()), 32'd0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        bit         prev_hold;
        logic [7:0] prev_data;
        exp_t       e;
        prev_hold = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                prev_hold = 1'b0;
            end else begin
                if (prev_hold) begin
                    chk("hold_valid", 32'(byte_valid), 32'd1);
                    chk("hold_data", 32'(byte_data), 32'(prev_data));
                end
                if (byte_valid && byte_ready) begin
                    if (exq.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_byte: actual 0x%0h required none", byte_data);
                    end else begin
                        e = exq.pop_front();
                        chk("byte_data", 32'(byte_data), 32'(e.d));
                        chk("byte_last", 32'(byte_last), 32'(e.l));
                    end
                end
                prev_hold = byte_valid && !byte_ready;
                prev_data = byte_data;
            end
        end
    end

    initial begin : stimulus
        int n_sym;
        int l;
        n_checks   = 0;
        n_fail     = 0;
        br_mode    = 1'b0;
        br_val     = 1'b1;
        reset_n    = 1'b0;
        code_valid = 1'b0;
        sym_valid  = 1'b0;
        sym_data   = '0;
        flush      = 1'b0;
        for (int i = 0; i < 6; i++) begin
            hc[i] = '0;
            m[i]  = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_byte_valid", 32'(byte_valid), 32'd0);
        chk("rst_byte_data", 32'(byte_data), 32'd0);
        chk("rst_byte_last", 32'(byte_last), 32'd0);
        chk("rst_sym_ready", 32'(sym_ready), 32'd0);
        chk("rst_sym_err", 32'(sym_err), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // T1: 1,2,3,4 then flush -> 0x5B, 0x80(last)
        set_std_table();
        load_table();
        send_sym(8'd1, 1'b0);
        send_sym(8'd2, 1'b0);
        send_sym(8'd3, 1'b0);
        send_sym(8'd4, 1'b0);
        @(negedge clk);
        chk("t1_latency_valid", 32'(byte_valid), 32'd1);
        chk("t1_latency_data", 32'(byte_data), 32'h5B);
`ifdef PACKER_STATS_EN
        chk("t6_total_bits", 32'(total_bits), 32'd10);
`endif
        do_flush();
        wait_drain("t1_drain");

        // T2: eight 1-bit zeros, flush while byte held -> 0x00 last
        br_val = 1'b0;
        set_std_table();
        load_table();
        repeat (8) send_sym(8'd1, 1'b0);
        @(negedge clk);
        chk("t2_byte_valid", 32'(byte_valid), 32'd1);
        chk("t2_byte_data", 32'(byte_data), 32'h00);
        do_flush();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("t2_last_marked", 32'(byte_last), 32'd1);
        br_val = 1'b1;
        wait_drain("t2_drain");

        // T3: stalled output, accumulator fills past a byte -> sym_ready drops
        br_val = 1'b0;
        set_std_table();
        load_table();
        repeat (4) send_sym(8'd6, 1'b0);
        repeat (5) begin
            @(negedge clk);
            chk("t3_sym_ready", 32'(sym_ready), 32'd0);
            chk("t3_held_data", 32'(byte_data), 32'hFF);
        end
        br_val = 1'b1;
        do_flush();
        wait_drain("t3_drain");

        // Randomized tables and streams with random back-pressure
        br_mode = 1'b1;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 6; i++) begin
                l     = (i == 0) ? int'($urandom_range(1, 8)) : int'($urandom_range(0, 8));
                m[i]  = 8'((1 << l) - 1);
                hc[i] = 8'($urandom);
            end
            load_table();
            n_sym = int'($urandom_range(15, 40));
            for (int s = 0; s < n_sym; s++) begin
                send_sym(8'($urandom_range(1, 6)), 1'b0);
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
            if ($urandom_range(0, 1) == 1) begin
                send_sym(8'd1, 1'b1);
            end else begin
                if (mq.size() == 0) send_sym(8'd1, 1'b0);
                do_flush();
            end
            wait_drain("rand_drain");
        end
        br_mode = 1'b0;
        br_val  = 1'b1;
        @(negedge clk);
        chk("sym_err_clean", 32'(sym_err), 32'd0);

        // T4: illegal symbol 7 then symbol 2 -> sym_err, 0x80 last
        set_std_table();
        load_table();
        send_sym(8'd7, 1'b0);
        send_sym(8'd2, 1'b0);
        do_flush();
        wait_drain("t4_drain");
        chk("t4_sym_err", 32'(sym_err), 32'd1);

        // T5: reset with 5 bits buffered, partial byte discarded
        set_std_table();
        load_table();
        send_sym(8'd5, 1'b0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        mq.delete();
        exq.delete();
        #1;
        chk("t5_byte_valid", 32'(byte_valid), 32'd0);
        chk("t5_byte_data", 32'(byte_data), 32'd0);
        chk("t5_byte_last", 32'(byte_last), 32'd0);
        chk("t5_sym_ready", 32'(sym_ready), 32'd0);
        chk("t5_sym_err", 32'(sym_err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("t5_idle_no_byte", 32'(byte_valid), 32'd0);
            chk("t5_idle_not_ready", 32'(sym_ready), 32'd0);
        end
        #1;
        load_table();
        send_sym(8'd2, 1'b0);
        do_flush();
        wait_drain("t5_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
